// File: rtl/jtframe_sub_bridge_pkg.sv
// Shared definitions for the main/sub CPU bridge: halt handshake states,
// default address-nibble decodes and a small write-decode helper.
package jtframe_sub_bridge_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    REQ  = 2'd1,
    HELD = 2'd2,
    REL  = 2'd3
  } halt_st_e;

  localparam logic [3:0] SH_NIB_DEF  = 4'hC;
  localparam logic [3:0] IRQ_NIB_DEF = 4'hD;
  localparam logic [3:0] ACK_NIB_DEF = 4'hE;
  localparam int         RST_CW      = 8;

  // True when the sub CPU presents a write cycle into the given 4 KB page
  function automatic logic sub_wr_to(input logic [15:0] a, input logic mreq_n,
                                     input logic wrn, input logic [3:0] nib);
    return !mreq_n && !wrn && (a[15:12] == nib);
  endfunction

endpackage

// File: rtl/jtframe_sub_bridge_dual_ram.sv
// Simple true dual-port RAM, one clock, registered read on both ports.
module jtframe_dual_ram #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic [AW-1:0] addr_a,
  input  logic [7:0]    data_a,
  input  logic          we_a,
  output logic [7:0]    q_a,
  input  logic [AW-1:0] addr_b,
  input  logic [7:0]    data_b,
  input  logic          we_b,
  output logic [7:0]    q_b
);

  logic [7:0] mem [0:(1<<AW)-1];

  // Both ports write and read the array; read returns the pre-write contents
  // NOTE: the storage array has no reset -- RAM contents are undefined at power-up and a reset loop would prevent block-RAM mapping.
  always_ff @(posedge clk) begin
    if (we_a) mem[addr_a] <= data_a;
    if (we_b) mem[addr_b] <= data_b;
    q_a <= mem[addr_a];
    q_b <= mem[addr_b];
  end

endmodule

// File: rtl/jtframe_sub_bridge.sv
// Main CPU <-> Z80-class sub CPU bridge: shared RAM, sub reset stretcher,
// NMI latch with memory-mapped ack, IRQ to main, bus-halt handshake and
// optional write guard on the main side.
module jtframe_sub_bridge
  import jtframe_sub_bridge_pkg::*;
#(
  parameter int         AW      = 10,
  parameter int         MAIN_AW = 9,
  parameter int         RST_LEN = 15,
  parameter logic [3:0] SH_NIB  = SH_NIB_DEF,
  parameter logic [3:0] IRQ_NIB = IRQ_NIB_DEF,
  parameter logic [3:0] ACK_NIB = ACK_NIB_DEF,
  parameter int         GUARD   = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cen,
  input  logic               mcu_rstb,
  input  logic [MAIN_AW-1:0] main_addr,
  input  logic               main_wrn,
  input  logic [7:0]         main_dout,
  input  logic               main_cs,
  output logic [7:0]         shared_dout,
  input  logic               halt_req,
  output logic               halted,
  input  logic               nmi_set,
  output logic               irq_main,
  input  logic               irq_ack,
  output logic [7:0]         drop_cnt,
  output logic               sub_rstn,
  output logic               sub_busrq_n,
  input  logic               sub_busak_n,
  output logic               sub_nmi_n,
  input  logic [15:0]        sub_A,
  input  logic               sub_mreq_n,
  input  logic               sub_wrn,
  input  logic [7:0]         sub_dout,
  output logic [7:0]         sub_din,
  output logic               rom_cs,
  input  logic [7:0]         rom_data
);

  logic [RST_CW-1:0] rst_cnt;
  logic              lrst;
  logic              sh_cs;
  logic [7:0]        sub_q;
  logic [AW-1:0]     main_ext;
  logic              main_we, sub_we, main_rej, rej_last;
  logic              irq_wr, ack_wr;
  logic              nmi_last, nmi_rise, nmi_latch;
  halt_st_e          st;

  // Sub CPU and its side logic stay in reset until the stretcher releases it
  assign lrst = !rst_n || !sub_rstn;

  assign rom_cs   = !sub_mreq_n && (sub_A[15:14] != 2'b11);
  assign sh_cs    = !sub_mreq_n && (sub_A[15:12] == SH_NIB) && ((sub_A[11:0] >> AW) == 12'd0);
  assign irq_wr   = sub_wr_to(sub_A, sub_mreq_n, sub_wrn, IRQ_NIB);
  assign ack_wr   = sub_wr_to(sub_A, sub_mreq_n, sub_wrn, ACK_NIB);
  assign nmi_rise = cen && nmi_set && !nmi_last;

  assign main_ext = AW'(main_addr);
  assign main_we  = !main_wrn && main_cs && ((GUARD == 0) || halted);
  assign main_rej = !main_wrn && main_cs && (GUARD != 0) && !halted;
  // A coincident write to the same byte from main takes precedence
  assign sub_we   = !sub_wrn && sh_cs && !halted && !(main_we && (main_ext == sub_A[AW-1:0]));

  assign sub_nmi_n = ~nmi_latch;

  // Stretch the sub reset: count RST_LEN cen ticks, release on the tick that finds zero
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n || !mcu_rstb) begin
      rst_cnt  <= RST_CW'(RST_LEN);
      sub_rstn <= 1'b0;
    end else if (cen) begin
      if (rst_cnt != '0) rst_cnt  <= rst_cnt - 1'b1;
      else               sub_rstn <= 1'b1;
    end
  end

  // NMI edge latch: rising nmi_set on cen sets, sub write to the ack page clears; set wins
  always_ff @(posedge clk) begin
    if (lrst) begin
      nmi_last  <= 1'b0;
      nmi_latch <= 1'b0;
    end else begin
      if (cen) nmi_last <= nmi_set;
      if (nmi_rise)    nmi_latch <= 1'b1;
      else if (ack_wr) nmi_latch <= 1'b0;
    end
  end

  // IRQ to main: sub write to the IRQ page sets, irq_ack clears; set wins
  always_ff @(posedge clk) begin
    if (lrst)         irq_main <= 1'b0;
    else if (irq_wr)  irq_main <= 1'b1;
    else if (irq_ack) irq_main <= 1'b0;
  end

  // Bus-halt handshake with registered busrq_n/halted
  always_ff @(posedge clk) begin
    if (lrst) begin
      st          <= RUN;
      sub_busrq_n <= 1'b1;
      halted      <= 1'b0;
    end else begin
      case (st)
        RUN: if (halt_req) begin
          st          <= REQ;
          sub_busrq_n <= 1'b0;
        end
        REQ: if (!sub_busak_n) begin
          st     <= HELD;
          halted <= 1'b1;
        end else if (!halt_req) begin
          st          <= RUN;
          sub_busrq_n <= 1'b1;
        end
        HELD: if (!halt_req) begin
          st          <= REL;
          sub_busrq_n <= 1'b1;
          halted      <= 1'b0;
        end
        REL: if (sub_busak_n) begin
          st <= RUN;
        end else if (halt_req) begin
          st          <= REQ;
          sub_busrq_n <= 1'b0;
        end
        default: st <= RUN;
      endcase
    end
  end

  // Count guarded main writes once per strobe, saturating at 255
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rej_last <= 1'b0;
      drop_cnt <= 8'd0;
    end else begin
      rej_last <= main_rej;
      if (main_rej && !rej_last && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  // Sub read mux: ROM first, then shared RAM, open bus otherwise
  always_comb begin
    // NOTE: default assignment first so no path through the block leaves sub_din unassigned (no latch).
    sub_din = 8'hFF;
    if (rom_cs)     sub_din = rom_data;
    else if (sh_cs) sub_din = sub_q;
  end

  jtframe_dual_ram #(.AW(AW)) u_ram (
    .clk    (clk),
    .addr_a (sub_A[AW-1:0]),
    .data_a (sub_dout),
    .we_a   (sub_we),
    .q_a    (sub_q),
    .addr_b (main_ext),
    .data_b (main_dout),
    .we_b   (main_we),
    .q_b    (shared_dout)
  );

endmodule

// File: doc/jtframe_sub_bridge.md
# jtframe_sub_bridge

Parametrised bridge between a main CPU and a Z80-class sub CPU. It owns the shared dual-port RAM, the sub-CPU reset stretcher, and the NMI edge latch with memory-mapped acknowledge. It also generates a latched IRQ to the main CPU, runs a bus-halt handshake FSM, and can optionally guard main-side writes. It sits between the main CPU bus decoder and the sub-CPU core plus ROM interface.

## Interface
Parameters:
- AW, 10: shared RAM address width (depth 2^AW bytes).
- MAIN_AW, 9: main-side address width; must satisfy MAIN_AW ≤ AW; zero-extended to AW.
- RST_LEN, 15: sub reset stretch, in cen ticks; counter width 8.
- SH_NIB, 4'hC: sub A[15:12] value that selects shared RAM; A[11:AW] must also be 0.
- IRQ_NIB, 4'hD: sub write to this nibble sets irq_main.
- ACK_NIB, 4'hE: sub write to this nibble clears the NMI latch.
- GUARD, 0: 1 means main writes are accepted only in state HELD.

Ports:
- clk in 1: system clock.
- rst_n in 1: synchronous, active-low reset.
- cen in 1: sub-CPU clock enable.
- mcu_rstb in 1: game-driven sub reset, active low.
- main_addr in MAIN_AW: main address into shared RAM.
- main_wrn in 1: main write strobe, active low.
- main_dout in 8: main write data.
- main_cs in 1: shared RAM select from the main decoder.
- shared_dout out 8: main read data.
- halt_req in 1: main asks for the sub bus.
- halted out 1: sub bus granted (FSM in HELD).
- nmi_set in 1: rising edge raises the sub NMI.
- irq_main out 1: latched IRQ to main.
- irq_ack in 1: main clears irq_main.
- drop_cnt out 8: saturating count of main writes rejected by GUARD.
- sub_rstn out 1: sub CPU reset, active low.
- sub_busrq_n out 1: bus request to the sub CPU.
- sub_busak_n in 1: bus acknowledge from the sub CPU.
- sub_nmi_n out 1: sub NMI, active low.
- sub_A in 16: sub address.
- sub_mreq_n in 1: sub memory request.
- sub_wrn in 1: sub write strobe.
- sub_dout in 8: sub write data.
- sub_din out 8: sub read data.
- rom_cs out 1: sub ROM select.
- rom_data in 8: ROM read data.

## Operation
- Reset values: sub_rstn=0, sub_busrq_n=1, sub_nmi_n=1, irq_main=0, halted=0, drop_cnt=0, FSM=RUN.
- Reset stretcher: while !rst_n or !mcu_rstb, counter loads RST_LEN and sub_rstn=0. Counter decrements on each cen. sub_rstn goes to 1 on the clk after the counter reads 0.
- While sub_rstn=0, the NMI latch, the irq latch and the FSM are held in reset.
- Sub decode is combinational:
  - rom_cs = !mreq_n && A[15:14]!=2'b11.
  - sh_cs = !mreq_n && A[15:12]==SH_NIB && A[11:AW]==0.
- sub_din priority: rom_data, then shared q, then 8'hFF.
- NMI latch: a rising edge of nmi_set, sampled on cen, sets the latch. Registered sub write with A[15:12]==ACK_NIB clears it. If set and clear fall in the same cycle, set wins. sub_nmi_n = ~latch.
- IRQ latch: registered sub write with A[15:12]==IRQ_NIB sets irq_main; irq_ack clears it. If both occur in the same cycle, set wins.
- Halt FSM:
  - RUN: halt_req → REQ, sub_busrq_n=0.
  - REQ: sub_busak_n=0 → HELD; halt_req=0 → RUN.
  - HELD: halted=1; halt_req=0 → REL, sub_busrq_n=1.
  - REL: sub_busak_n=1 → RUN; halt_req=1 → REQ.
- Shared RAM port A (sub): write enable = !sub_wrn && sh_cs && !halted.
- Shared RAM port B (main): write enable = !main_wrn && main_cs && (!GUARD || halted).
- Each rejected main write increments drop_cnt once per write strobe (edge-detected), saturating at 255.
- Same-address, same-cycle writes on both ports: main wins and the sub write is suppressed.

## Timing
- RAM read latency is 1 clk on both ports; address at edge N, data valid after edge N+1.
- IRQ and NMI-ack decode are registered. irq_main rises 1 clk after the sub write cycle is presented.
- nmi_set to sub_nmi_n=0: first cen after the edge, plus 1 clk.
- Halt: sub_busrq_n asserts 1 clk after halt_req rises. halted asserts 1 clk after busak_n is seen low.
- If rst_n drops mid-handshake, the FSM returns to RUN and sub_busrq_n=1 on the next clk.

## Structure
- The shared package holds the FSM state enum (RUN, REQ, HELD, REL) and the default nibble constants.
- Natural sub-module: jtframe_dual_ram (AW wide), used for the shared RAM.
- The reset stretcher, latches and FSM stay inline.

## Test plan
- Reset: hold rst_n=0 for 3 clk, then release with cen every 4 clk and RST_LEN=15 → sub_rstn rises after the 16th cen tick; all other outputs at their reset values.
- Shared RAM: sub writes 0x5A to 0xC123 (AW=10) → main reads 0x5A at main_addr 0x123 1 clk later. Main writes 0xA5 → sub reads 0xA5 on sub_din.
- NMI: nmi_set edge → sub_nmi_n=0. Sub write to 0xE000 → sub_nmi_n=1 on the next clk. Coincident edge and ack → sub_nmi_n stays 0.
- IRQ: sub write to 0xD000 → irq_main=1 until irq_ack. irq_ack in the same cycle as a new write → irq_main stays 1.
- Halt: raise halt_req and assert busak_n 5 clk later → halted=1. Drop halt_req → sub_busrq_n=1, and the FSM returns to RUN after busak_n=1.
- Guard: GUARD=1 in RUN, 3 main writes → RAM unchanged, drop_cnt=3. Repeat in HELD → writes land. 300 rejected writes → drop_cnt=255.
